// File: rtl/evm_stack.sv
// ---------------------------------------------------------------------------
// evm_stack
//
// Operand stack for the EVM core. Holds up to DEPTH words of WIDTH bits. The
// top WIN entries live in a register window (index 0 = top of stack); deeper
// entries live in a synchronous single-port RAM. A push that overflows the
// window spills the bottom window slot to RAM in the same cycle. A pop that
// uncovers entries held only in RAM refills the window one word per cycle.
// op_ready is held low while the refill runs.
//
// Handshake: an operation is accepted on a rising edge where op_valid and
// op_ready are both high. op_ready depends only on internal state, never on
// op_valid. Consumers must not use stack_data while op_ready is low.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid        operation request
//   op_ready        stack can accept an operation this cycle
//   pop_num [4:0]   entries to pop (0..16); larger values are an underflow
//   push_en         push one word after the pop
//   push_data       word to push
//   stack_height    current entry count
//   stack_data      window; [i] = i-th entry from top, 0 where no entry
//   err_underflow   one-cycle pulse: op rejected, too few entries
//   err_overflow    one-cycle pulse: op rejected, stack would exceed DEPTH
// ---------------------------------------------------------------------------
module evm_stack #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 256,
    parameter int WIN   = 16,
    parameter int HW    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [4:0]                 pop_num,
    input  logic                       push_en,
    input  logic [WIDTH-1:0]           push_data,
    output logic [HW-1:0]              stack_height,
    output logic [WIN-1:0][WIDTH-1:0]  stack_data,
    output logic                       err_underflow,
    output logic                       err_overflow
);

    localparam int AW = $clog2(DEPTH);   // RAM address width
    localparam int SW = $clog2(WIN);     // window slot index width

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_e;

    // Registered state
    state_e                     state_q, state_d;
    logic                       op_ready_q, op_ready_d;
    logic [HW-1:0]              height_q, height_d;
    logic [WIN-1:0][WIDTH-1:0]  win_q, win_d;
    logic                       err_uf_q, err_uf_d;
    logic                       err_of_q, err_of_d;
    logic [SW:0]                issue_left_q, issue_left_d;  // RAM reads still to issue
    logic [SW-1:0]              fill_slot_q, fill_slot_d;    // slot of next read
    logic [AW-1:0]              fill_addr_q, fill_addr_d;    // address of next read
    logic                       rd_pending_q, rd_pending_d;  // a read returns this cycle
    logic [SW-1:0]              rd_slot_q, rd_slot_d;        // slot that read lands in

    // RAM
    logic [WIDTH-1:0]           mem [DEPTH];
    logic                       ram_we;
    logic [AW-1:0]              ram_addr;
    logic [WIDTH-1:0]           ram_wdata;
    logic [WIDTH-1:0]           ram_rdata_q;

    // Operation decode
    logic                       accept;
    logic [HW-1:0]              p_ext;
    logic [HW-1:0]              u_ext;
    logic                       is_underflow;
    logic                       is_overflow;
    logic [HW-1:0]              h_popped;
    logic [HW-1:0]              h_next;
    logic                       pure_push;
    logic [4:0]                 shift_k;
    logic [4:0]                 shift_base;  // first slot not covered by the shift
    logic [4:0]                 refill_lim;
    logic [4:0]                 refill_n;
    logic [AW-1:0]              refill_first;
    logic [4:0]                 src_idx;

    assign accept = op_valid && op_ready_q;

    always_comb begin
        p_ext        = {{(HW-5){1'b0}}, pop_num};
        u_ext        = {{(HW-1){1'b0}}, push_en};
        is_underflow = (pop_num > 5'(WIN)) || (p_ext > height_q);
        h_popped     = height_q - p_ext;
        // Height can only exceed DEPTH when the pop leaves the stack full.
        is_overflow  = !is_underflow && push_en && (h_popped == HW'(DEPTH));
        h_next       = h_popped + u_ext;
        pure_push    = push_en && (pop_num == 5'd0);
        shift_k      = pop_num - {4'd0, push_en};
        shift_base   = 5'(WIN) - shift_k;

        // Slots shift_base..WIN-1 are uncovered by the shift. The ones that
        // still hold an entry (absolute position h_next-1-i >= 0) form a
        // contiguous run starting at shift_base, filled from RAM downward.
        refill_lim   = (h_next >= HW'(WIN)) ? 5'(WIN) : h_next[4:0];
        refill_n     = 5'd0;
        refill_first = AW'(h_next - {{(HW-5){1'b0}}, shift_base} - 1'b1);
        if (!pure_push && (shift_k != 5'd0) &&
            (h_next > {{(HW-5){1'b0}}, shift_base})) begin
            refill_n = refill_lim - shift_base;
        end
    end

    always_comb begin
        state_d      = state_q;
        height_d     = height_q;
        win_d        = win_q;
        err_uf_d     = 1'b0;
        err_of_d     = 1'b0;
        issue_left_d = issue_left_q;
        fill_slot_d  = fill_slot_q;
        fill_addr_d  = fill_addr_q;
        rd_pending_d = 1'b0;
        rd_slot_d    = rd_slot_q;
        ram_we       = 1'b0;
        ram_addr     = fill_addr_q;
        ram_wdata    = win_q[WIN-1];
        src_idx      = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_underflow) begin
                        err_uf_d = 1'b1;
                    end else if (is_overflow) begin
                        err_of_d = 1'b1;
                    end else begin
                        height_d = h_next;
                        if (pure_push) begin
                            win_d[0] = push_data;
                            for (int i = 1; i < WIN; i++) begin
                                win_d[i] = win_q[i-1];
                            end
                            // The bottom window word leaves the window; it
                            // is only a real entry once the window is full.
                            if (height_q >= HW'(WIN)) begin
                                ram_we   = 1'b1;
                                ram_addr = AW'(height_q - HW'(WIN));
                            end
                        end else begin
                            // Shift up by k; uncovered slots read 0 until
                            // the refill overwrites the ones that hold data.
                            for (int i = 0; i < WIN; i++) begin
                                src_idx = 5'(i) + shift_k;
                                if (src_idx < 5'(WIN)) begin
                                    win_d[i] = win_q[src_idx[SW-1:0]];
                                end else begin
                                    win_d[i] = '0;
                                end
                            end
                            if (push_en) begin
                                win_d[0] = push_data;
                            end
                            if (refill_n != 5'd0) begin
                                state_d      = S_FILL;
                                issue_left_d = refill_n;
                                fill_slot_d  = shift_base[SW-1:0];
                                fill_addr_d  = refill_first;
                            end
                        end
                    end
                end
            end

            S_FILL: begin
                if (issue_left_q != '0) begin
                    ram_addr     = fill_addr_q;
                    rd_pending_d = 1'b1;
                    rd_slot_d    = fill_slot_q;
                    fill_slot_d  = fill_slot_q + 1'b1;
                    fill_addr_d  = fill_addr_q - 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                end
                if (rd_pending_q) begin
                    win_d[rd_slot_q] = ram_rdata_q;
                end
                // Leave once every read is issued and the final one lands.
                if ((issue_left_q == '0) && rd_pending_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        op_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_ready_q   <= 1'b1;
            height_q     <= '0;
            win_q        <= '0;
            err_uf_q     <= 1'b0;
            err_of_q     <= 1'b0;
            issue_left_q <= '0;
            fill_slot_q  <= '0;
            fill_addr_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_slot_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_ready_q   <= op_ready_d;
            height_q     <= height_d;
            win_q        <= win_d;
            err_uf_q     <= err_uf_d;
            err_of_q     <= err_of_d;
            issue_left_q <= issue_left_d;
            fill_slot_q  <= fill_slot_d;
            fill_addr_q  <= fill_addr_d;
            rd_pending_q <= rd_pending_d;
            rd_slot_q    <= rd_slot_d;
        end
    end

    // Single-port RAM, one-cycle read latency. Writes happen only in IDLE and
    // reads only in FILL, so one shared address never collides.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata_q <= mem[ram_addr];
    end

    assign op_ready      = op_ready_q;
    assign stack_height  = height_q;
    assign stack_data    = win_q;
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;

endmodule

// File: tb/tb_evm_stack.sv
// ---------------------------------------------------------------------------
// tb_evm_stack
//
// Self-checking bench for evm_stack. The reference model is the stack itself:
// a queue of words with the bottom entry at index 0. Window contents, height,
// error pulses and the number of stall cycles all come from that queue and
// from the stack rules. Inputs are driven 1 ns after the rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_evm_stack;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 256;
    localparam int WIN   = 16;
    localparam int HW    = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                      op_valid;
    logic                      op_ready;
    logic [4:0]                pop_num;
    logic                      push_en;
    logic [WIDTH-1:0]          push_data;
    logic [HW-1:0]             stack_height;
    logic [WIN-1:0][WIDTH-1:0] stack_data;
    logic                      err_underflow;
    logic                      err_overflow;

    evm_stack #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .WIN(WIN), .HW(HW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .pop_num       (pop_num),
        .push_en       (push_en),
        .push_data     (push_data),
        .stack_height  (stack_height),
        .stack_data    (stack_data),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] exp_q[$];   // bottom of stack at index 0
    logic mdl_uf, mdl_of;
    int   mdl_stall;

    function automatic logic [WIDTH-1:0] mdl_win(input int i);
        int a;
        a = exp_q.size() - 1 - i;
        if (a >= 0) return exp_q[a];
        return '0;
    endfunction

    task automatic model_apply(input int p, input bit u, input logic [WIDTH-1:0] d);
        int h, hn, k, n;
        h = exp_q.size();
        mdl_uf = 1'b0;
        mdl_of = 1'b0;
        mdl_stall = 0;
        if (p > WIN || p > h) begin
            mdl_uf = 1'b1;
        end else if (h - p + int'(u) > DEPTH) begin
            mdl_of = 1'b1;
        end else begin
            hn = h - p + int'(u);
            k  = p - int'(u);
            n  = 0;
            if (k >= 1) begin
                for (int i = WIN - k; i < WIN; i++) begin
                    if (hn - 1 - i >= 0) n++;
                end
            end
            mdl_stall = (n > 0) ? n + 1 : 0;
            repeat (p) void'(exp_q.pop_back());
            if (u) exp_q.push_back(d);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int j = 0; j < WIDTH / 32; j++) w[32*j +: 32] = $urandom;
        return w;
    endfunction

    // ---------------- drivers ----------------
    logic            obs_uf, obs_of, obs_uf2, obs_of2;
    logic [HW-1:0]   obs_h;
    int              obs_stall;

    task automatic do_reset();
        rst = 1'b1;
        op_valid = 1'b0;
        pop_num = '0;
        push_en = 1'b0;
        push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    // One op; records flags at T+1, stall length, and flags one cycle later.
    task automatic do_op(input int p, input bit u, input logic [WIDTH-1:0] d);
        int guard;
        guard = 0;
        while (op_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        model_apply(p, u, d);
        op_valid = 1'b1; pop_num = 5'(p); push_en = u; push_data = d;
        @(posedge clk); #1;
        op_valid = 1'b0; pop_num = '0; push_en = 1'b0;
        obs_uf = err_underflow; obs_of = err_overflow; obs_h = stack_height;
        obs_stall = 0;
        while (op_ready !== 1'b1 && obs_stall < 200) begin
            @(posedge clk); #1; obs_stall++;
        end
        @(posedge clk); #1;
        obs_uf2 = err_underflow; obs_of2 = err_overflow;
    endtask

    // Back-to-back pushes with op_valid held high; counts cycles op_ready was low.
    task automatic push_burst(input int cnt, input int base, input bit rnd);
        logic [WIDTH-1:0] d;
        obs_stall = 0;
        for (int j = 0; j < cnt; j++) begin
            d = rnd ? rand_word() : WIDTH'(base + j);
            op_valid = 1'b1; pop_num = '0; push_en = 1'b1; push_data = d;
            @(posedge clk); #1;
            if (op_ready !== 1'b1) obs_stall++;
            exp_q.push_back(d);
        end
        op_valid = 1'b0; push_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", op_ready); end
        n_vec++; if (stack_height !== '0) begin n_err++; $display("FAIL reset_height got %0d exp 0", stack_height); end
        n_vec++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_err got uf=%b of=%b exp 0 0", err_underflow, err_overflow); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== '0) begin n_err++; $display("FAIL reset_win[%0d] got %h exp 0", i, stack_data[i]); end
        end
    endtask

    task automatic test_push3();
        logic [WIDTH-1:0] d;
        do_reset();
        obs_stall = 0;
        for (int j = 0; j < 3; j++) begin
            d = WIDTH'(32'hA + j);
            op_valid = 1'b1; push_en = 1'b1; pop_num = '0; push_data = d;
            @(posedge clk); #1;
            exp_q.push_back(d);
            n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL push3_ready cycle %0d got %b exp 1", j, op_ready); end
        end
        op_valid = 1'b0; push_en = 1'b0;
        n_vec++; if (stack_height !== 11'd3) begin n_err++; $display("FAIL push3_height got %0d exp 3", stack_height); end
        n_vec++; if (stack_data[0] !== WIDTH'(32'hC)) begin n_err++; $display("FAIL push3_top got %h exp c", stack_data[0]); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== mdl_win(i)) begin n_err++; $display("FAIL push3_win[%0d] got %h exp %h", i, stack_data[i], mdl_win(i)); end
        end
    endtask

    task automatic test_pop_refill();
        do_reset();
        push_burst(20, 1, 1'b0);
        n_vec++; if (obs_stall !== 0) begin n_err++; $display("FAIL burst20_stall got %0d exp 0", obs_stall); end
        do_op(2, 1'b0, '0);
        n_vec++; if (obs_h !== 11'd18) begin n_err++; $display("FAIL pop2_height got %0d exp 18", obs_h); end
        n_vec++; if (obs_stall !== mdl_stall || obs_stall !== 3) begin n_err++; $display("FAIL pop2_stall got %0d exp %0d", obs_stall, mdl_stall); end
        n_vec++; if (stack_data[0] !== WIDTH'(18)) begin n_err++; $display("FAIL pop2_top got %h exp 12", stack_data[0]); end
        n_vec++; if (stack_data[15] !== WIDTH'(3)) begin n_err++; $display("FAIL pop2_bot got %h exp 3", stack_data[15]); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== mdl_win(i)) begin n_err++; $display("FAIL pop2_win[%0d] got %h exp %h", i, stack_data[i], mdl_win(i)); end
        end
    endtask

    task automatic test_swap_top();
        do_reset();
        push_burst(20, 1, 1'b0);
        do_op(1, 1'b1, WIDTH'(32'h55));
        n_vec++; if (obs_h !== 11'd20) begin n_err++; $display("FAIL swap_height got %0d exp 20", obs_h); end
        n_vec++; if (obs_stall !== 0) begin n_err++; $display("FAIL swap_stall got %0d exp 0", obs_stall); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== mdl_win(i)) begin n_err++; $display("FAIL swap_win[%0d] got %h exp %h", i, stack_data[i], mdl_win(i)); end
        end
    endtask

    task automatic test_errors();
        do_reset();
        do_op(1, 1'b0, '0);
        n_vec++; if (obs_uf !== 1'b1 || obs_of !== 1'b0) begin n_err++; $display("FAIL uf_pulse got uf=%b of=%b exp 1 0", obs_uf, obs_of); end
        n_vec++; if (obs_uf2 !== 1'b0) begin n_err++; $display("FAIL uf_width got %b exp 0", obs_uf2); end
        n_vec++; if (obs_h !== 11'd0) begin n_err++; $display("FAIL uf_height got %0d exp 0", obs_h); end
        push_burst(DEPTH, 0, 1'b1);
        n_vec++; if (obs_stall !== 0) begin n_err++; $display("FAIL fill_stall got %0d exp 0", obs_stall); end
        n_vec++; if (stack_height !== 11'd1024) begin n_err++; $display("FAIL full_height got %0d exp 1024", stack_height); end
        do_op(0, 1'b1, rand_word());
        n_vec++; if (obs_of !== 1'b1 || obs_uf !== 1'b0) begin n_err++; $display("FAIL of_pulse got uf=%b of=%b exp 0 1", obs_uf, obs_of); end
        n_vec++; if (obs_of2 !== 1'b0) begin n_err++; $display("FAIL of_width got %b exp 0", obs_of2); end
        n_vec++; if (obs_h !== 11'd1024) begin n_err++; $display("FAIL of_height got %0d exp 1024", obs_h); end
        // Deep refill of the whole window from RAM.
        do_op(16, 1'b0, '0);
        n_vec++; if (obs_h !== 11'(exp_q.size())) begin n_err++; $display("FAIL pop16_height got %0d exp %0d", obs_h, exp_q.size()); end
        n_vec++; if (obs_stall !== mdl_stall) begin n_err++; $display("FAIL pop16_stall got %0d exp %0d", obs_stall, mdl_stall); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== mdl_win(i)) begin n_err++; $display("FAIL pop16_win[%0d] got %h exp %h", i, stack_data[i], mdl_win(i)); end
        end
        do_op(17, 1'b0, '0);
        n_vec++; if (obs_uf !== mdl_uf || obs_uf !== 1'b1) begin n_err++; $display("FAIL pop17_uf got %b exp 1", obs_uf); end
        n_vec++; if (obs_h !== 11'd1008) begin n_err++; $display("FAIL pop17_height got %0d exp 1008", obs_h); end
    endtask

    task automatic test_refill_reset();
        do_reset();
        push_burst(20, 1, 1'b0);
        op_valid = 1'b1; pop_num = 5'd16; push_en = 1'b0;
        @(posedge clk); #1;                       // cycle T+1
        op_valid = 1'b0; pop_num = '0;
        n_vec++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL rr_ready_t1 got %b exp 0", op_ready); end
        @(posedge clk); #1;                       // cycle T+2: second fill cycle
        n_vec++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL rr_ready_t2 got %b exp 0", op_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        n_vec++; if (stack_height !== '0) begin n_err++; $display("FAIL rr_height got %0d exp 0", stack_height); end
        n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready got %b exp 1", op_ready); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== '0) begin n_err++; $display("FAIL rr_win[%0d] got %h exp 0", i, stack_data[i]); end
        end
        // Nothing from the abandoned fill may land after reset.
        do_op(0, 1'b1, WIDTH'(32'h77));
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== mdl_win(i)) begin n_err++; $display("FAIL rr_after_win[%0d] got %h exp %h", i, stack_data[i], mdl_win(i)); end
        end
    endtask

    task automatic test_pop5_push();
        do_reset();
        push_burst(17, 100, 1'b0);
        do_op(5, 1'b1, WIDTH'(32'hABCD));
        n_vec++; if (obs_h !== 11'd13) begin n_err++; $display("FAIL p5u_height got %0d exp 13", obs_h); end
        n_vec++; if (obs_stall !== 2) begin n_err++; $display("FAIL p5u_stall got %0d exp 2", obs_stall); end
        n_vec++; if (stack_data[12] !== WIDTH'(100)) begin n_err++; $display("FAIL p5u_slot12 got %h exp 64", stack_data[12]); end
        for (int i = 0; i < WIN; i++) begin
            n_vec++; if (stack_data[i] !== mdl_win(i)) begin n_err++; $display("FAIL p5u_win[%0d] got %h exp %h", i, stack_data[i], mdl_win(i)); end
        end
    endtask

    task automatic test_random();
        int p;
        bit u;
        do_reset();
        push_burst(40, 0, 1'b1);
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) p = int'($urandom_range(0, 17));
            else p = int'($urandom_range(0, 4));
            if (exp_q.size() > 150) p = int'($urandom_range(1, 16));
            u = 1'($urandom_range(0, 1));
            do_op(p, u, rand_word());
            n_vec++; if (obs_uf !== mdl_uf || obs_of !== mdl_of) begin
                n_err++; $display("FAIL rnd%0d_err got uf=%b of=%b exp %b %b", t, obs_uf, obs_of, mdl_uf, mdl_of); end
            n_vec++; if (obs_h !== 11'(exp_q.size())) begin
                n_err++; $display("FAIL rnd%0d_height got %0d exp %0d", t, obs_h, exp_q.size()); end
            n_vec++; if (obs_stall !== mdl_stall) begin
                n_err++; $display("FAIL rnd%0d_stall got %0d exp %0d", t, obs_stall, mdl_stall); end
            n_vec++; if (obs_uf2 !== 1'b0 || obs_of2 !== 1'b0) begin
                n_err++; $display("FAIL rnd%0d_errlen got uf=%b of=%b exp 0 0", t, obs_uf2, obs_of2); end
            for (int i = 0; i < WIN; i++) begin
                n_vec++; if (stack_data[i] !== mdl_win(i)) begin
                    n_err++; $display("FAIL rnd%0d_win[%0d] got %h exp %h", t, i, stack_data[i], mdl_win(i)); end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_push3();
        test_pop_refill();
        test_swap_top();
        test_errors();
        test_refill_reset();
        test_pop5_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired after 3 ms of simulated time");
        $fatal(1, "watchdog");
    end

endmodule
